// File: rtl/obf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obf_pkg : shared types and constants for the obfuscated-FSM unlock sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package obf_pkg;

  localparam int         OBF_KEY_W        = 5;
  localparam int         OBF_STATE_W      = 4;
  localparam logic [3:0] OBF_INIT_STATE   = 4'b1000;
  localparam logic [3:0] OBF_UNLOCK_STATE = 4'b0000;
  localparam logic [3:0] OBF_BH_STATE     = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAIL  = 3'd4
  } ctrl_state_e;

  localparam logic [1:0] FAIL_NONE     = 2'd0;
  localparam logic [1:0] FAIL_NOT_INIT = 2'd1;
  localparam logic [1:0] FAIL_BH_LOAD  = 2'd2;
  localparam logic [1:0] FAIL_POST_KEY = 2'd3;

endpackage
`default_nettype wire

// File: rtl/obf_key_shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obf_key_shifter : parallel-load MSB-first key shifter with bit index/last flag
// Rev 1.0
// ---------------------------------------------------------------------------
module obf_key_shifter
  import obf_pkg::*;
#(
  parameter  int KEY_W = OBF_KEY_W,
  localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [KEY_W-1:0] key_in,
  output logic             bit_out,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  // The register holds only the bits not yet presented; the MSB is bypassed on load.
  logic [KEY_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (clear) begin
      shreg_d = '0;
      idx_d   = '0;
    end else if (load) begin
      shreg_d = key_in << 1;
      idx_d   = '0;
    end else if (shift) begin
      shreg_d = shreg_q << 1;
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign bit_out = load ? key_in[KEY_W-1] : shreg_q[KEY_W-1];
  assign idx     = idx_q;
  assign last    = (idx_q == IDX_W'(KEY_W-1));

endmodule
`default_nettype wire

// File: rtl/obf_unlock_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obf_unlock_seq : loads the unlock key into a locked FSM, then passes through
// functional input. Optional debug ports under OBF_UNLOCK_DBG_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module obf_unlock_seq
  import obf_pkg::*;
#(
  parameter  int                 KEY_W        = OBF_KEY_W,
  parameter  int                 STATE_W      = OBF_STATE_W,
  parameter  logic [STATE_W-1:0] INIT_STATE   = OBF_INIT_STATE,
  parameter  logic [STATE_W-1:0] UNLOCK_STATE = OBF_UNLOCK_STATE,
  parameter  logic [STATE_W-1:0] BH_STATE     = OBF_BH_STATE,
  localparam int                 IDX_W        = (KEY_W > 1) ? $clog2(KEY_W) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [KEY_W-1:0]   key_in,
  input  logic [STATE_W-1:0] fsm_state,
  input  logic               func_x,
  input  logic               func_valid,
  output logic               fsm_x,
  output logic               fsm_en,
  output logic               busy,
  output logic               unlocked,
  output logic               fail,
  output logic [1:0]         fail_code
`ifdef OBF_UNLOCK_DBG_EN
  ,
  output logic [2:0]         dbg_state,
  output logic [IDX_W-1:0]   dbg_idx
`endif
);

  ctrl_state_e state_q, state_d;
  logic        fsm_x_q, fsm_x_d, fsm_en_q, fsm_en_d, busy_q, busy_d;
  logic        unlocked_q, unlocked_d, fail_q, fail_d;
  logic [1:0]  fail_code_q, fail_code_d;

  logic             key_load, key_shift, key_clear, leave_load;
  logic             key_bit, key_last;
  logic [IDX_W-1:0] key_idx;

  obf_key_shifter #(.KEY_W(KEY_W)) u_key_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (key_load),
    .shift   (key_shift),
    .clear   (key_clear),
    .key_in  (key_in),
    .bit_out (key_bit),
    .idx     (key_idx),
    .last    (key_last)
  );

  // Outputs are computed for the next state so that every port comes straight off a flop.
  always_comb begin
    state_d     = state_q;
    fsm_x_d     = 1'b0;
    fsm_en_d    = 1'b0;
    busy_d      = 1'b0;
    unlocked_d  = 1'b0;
    fail_d      = fail_q;
    fail_code_d = fail_code_q;
    key_load    = 1'b0;
    key_shift   = 1'b0;
    leave_load  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (fsm_state == INIT_STATE) begin
            state_d  = ST_LOAD;
            key_load = 1'b1;
            fsm_en_d = 1'b1;
            fsm_x_d  = key_bit;
            busy_d   = 1'b1;
          end else begin
            state_d     = ST_FAIL;
            fail_d      = 1'b1;
            fail_code_d = FAIL_NOT_INIT;
          end
        end
      end
      ST_LOAD: begin
        // Blackhole wins over the last-bit transition to CHECK.
        if (fsm_state == BH_STATE) begin
          state_d     = ST_FAIL;
          fail_d      = 1'b1;
          fail_code_d = FAIL_BH_LOAD;
          leave_load  = 1'b1;
        end else if (key_last) begin
          state_d    = ST_CHECK;
          busy_d     = 1'b1;
          leave_load = 1'b1;
        end else begin
          key_shift = 1'b1;
          fsm_en_d  = 1'b1;
          fsm_x_d   = key_bit;
          busy_d    = 1'b1;
        end
      end
      ST_CHECK, ST_RUN: begin
        if ((state_q == ST_CHECK && fsm_state != UNLOCK_STATE) ||
            (state_q == ST_RUN && fsm_state == BH_STATE)) begin
          state_d     = ST_FAIL;
          fail_d      = 1'b1;
          fail_code_d = FAIL_POST_KEY;
        end else begin
          state_d    = ST_RUN;
          unlocked_d = 1'b1;
          fsm_x_d    = func_x;
          fsm_en_d   = func_valid;
        end
      end
      default: state_d = ST_FAIL;
    endcase
`ifdef OBF_UNLOCK_DBG_EN
    key_clear = 1'b0;
`else
    key_clear = leave_load;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fsm_x_q     <= 1'b0;
      fsm_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      unlocked_q  <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= FAIL_NONE;
    end else begin
      state_q     <= state_d;
      fsm_x_q     <= fsm_x_d;
      fsm_en_q    <= fsm_en_d;
      busy_q      <= busy_d;
      unlocked_q  <= unlocked_d;
      fail_q      <= fail_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign fsm_x     = fsm_x_q;
  assign fsm_en    = fsm_en_q;
  assign busy      = busy_q;
  assign unlocked  = unlocked_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;

`ifdef OBF_UNLOCK_DBG_EN
  assign dbg_state = state_q;
  assign dbg_idx   = key_idx;
`else
  logic unused_key_idx;
  assign unused_key_idx = ^key_idx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_obf_unlock_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_obf_unlock_seq : directed + randomized bench with a behavioural locked FSM
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_obf_unlock_seq;

  localparam logic [4:0] CORRECT = 5'b11110;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [4:0] key_in = '0;
  logic [3:0] fsm_state;
  logic       func_x = 1'b0, func_valid = 1'b0;
  logic       fsm_x, fsm_en, busy, unlocked, fail;
  logic [1:0] fail_code;
`ifdef OBF_UNLOCK_DBG_EN
  logic [2:0] dbg_state;
  logic [2:0] dbg_idx;
`endif

  int errors = 0;
  int checks = 0;

  // Locked FSM model: no reset, advances on fsm_en, preset/override by the bench.
  logic [3:0] fsm_st = 4'b1000;
  logic       preset_req = 1'b0;
  logic [3:0] preset_val = 4'b0000;
  logic       ovr_en = 1'b0;
  logic [3:0] ovr_val = 4'b0000;
  assign fsm_state = ovr_en ? ovr_val : fsm_st;

  obf_unlock_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .fsm_state  (fsm_state),
    .func_x     (func_x),
    .func_valid (func_valid),
    .fsm_x      (fsm_x),
    .fsm_en     (fsm_en),
    .busy       (busy),
    .unlocked   (unlocked),
    .fail       (fail),
    .fail_code  (fail_code)
`ifdef OBF_UNLOCK_DBG_EN
    ,
    .dbg_state  (dbg_state),
    .dbg_idx    (dbg_idx)
`endif
  );

  always #5 clk = ~clk;

  // Key region 1000..1100 tracks correct bits consumed; any wrong bit falls into 1111.
  always @(posedge clk) begin
    if (preset_req) fsm_st <= preset_val;
    else if (fsm_en) begin
      if (fsm_st == 4'b1111) fsm_st <= 4'b1111;
      else if (fsm_st[3]) begin
        if (fsm_st[2:0] > 3'd4) fsm_st <= 4'b1111;
        else if (fsm_x == CORRECT[3'd4 - fsm_st[2:0]])
          fsm_st <= (fsm_st[2:0] == 3'd4) ? 4'b0000 : fsm_st + 4'd1;
        else fsm_st <= 4'b1111;
      end else fsm_st <= {1'b0, fsm_st[1:0], fsm_x};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic prep(input logic [3:0] st);
    rst_n = 1'b0; start = 1'b0; func_valid = 1'b0; func_x = 1'b0; ovr_en = 1'b0;
    preset_val = st; preset_req = 1'b1;
    @(posedge clk); #1;
    preset_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Pulses start, then samples 8 cycles; sample s is taken #1 after the (s+1)-th edge.
  task automatic attempt(input logic [4:0] key, input bit zap, output int pulses,
                         output logic [4:0] xbits, output int busy_cnt,
                         output int fail_at, output int unlock_at);
    key_in = key; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (zap) key_in = 5'b00000;
    pulses = 0; xbits = '0; busy_cnt = 0; fail_at = -1; unlock_at = -1;
    for (int s = 0; s < 8; s++) begin
      if (fsm_en) begin
        xbits = {xbits[3:0], fsm_x};
        pulses++;
      end
      if (busy) busy_cnt++;
      if (fail && fail_at < 0) fail_at = s;
      if (unlocked && unlock_at < 0) unlock_at = s;
      @(posedge clk); #1;
    end
  endtask

  function automatic int first_wrong(input logic [4:0] k);
    for (int i = 0; i < 5; i++)
      if (k[4-i] !== CORRECT[4-i]) return i;
    return 5;
  endfunction

  task automatic run_and_check(input string tag, input logic [3:0] init_st,
                               input logic [4:0] key, input bit zap);
    int pulses, busy_cnt, fail_at, unlock_at, j;
    int e_pulses, e_busy, e_fail_at, e_unlock_at;
    logic [4:0] xbits, e_x;
    logic [1:0] e_code;
    prep(init_st);
    attempt(key, zap, pulses, xbits, busy_cnt, fail_at, unlock_at);
    if (init_st != 4'b1000) begin
      e_pulses = 0; e_busy = 0; e_fail_at = 0; e_unlock_at = -1; e_code = 2'd1;
    end else begin
      j = first_wrong(key);
      if (j == 5) begin
        e_pulses = 5; e_busy = 6; e_fail_at = -1; e_unlock_at = 6; e_code = 2'd0;
      end else begin
        e_pulses = (j + 2 > 5) ? 5 : j + 2;
        e_busy = j + 2; e_fail_at = j + 2; e_unlock_at = -1;
        e_code = (j <= 3) ? 2'd2 : 2'd3;
      end
    end
    e_x = key >> (5 - e_pulses);
    chk({tag, ".pulses"}, 32'(pulses), 32'(e_pulses));
    chk({tag, ".xbits"}, 32'(xbits), 32'(e_x));
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(e_busy));
    chk({tag, ".fail_at"}, 32'(fail_at), 32'(e_fail_at));
    chk({tag, ".unlock_at"}, 32'(unlock_at), 32'(e_unlock_at));
    chk({tag, ".fail"}, 32'(fail), 32'(e_code != 2'd0));
    chk({tag, ".fail_code"}, 32'(fail_code), 32'(e_code));
  endtask

  initial begin
    logic [4:0] rk;
    logic [3:0] rs;
    logic [1:0] vx [5];

    // Reset state
    #1;
    chk("rst.fsm_x", 32'(fsm_x), 0);
    chk("rst.fsm_en", 32'(fsm_en), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.unlocked", 32'(unlocked), 0);
    chk("rst.fail", 32'(fail), 0);
    chk("rst.fail_code", 32'(fail_code), 0);

    // Correct key, then functional pass-through, then blackhole in RUN
    run_and_check("good", 4'b1000, CORRECT, 1'b0);
    vx[0] = 2'b11; vx[1] = 2'b11; vx[2] = 2'b10; vx[3] = 2'b01; vx[4] = 2'b11;
    for (int i = 0; i < 5; i++) begin
      func_valid = vx[i][1]; func_x = vx[i][0];
      @(posedge clk); #1;
      chk($sformatf("run%0d.fsm_en", i), 32'(fsm_en), 32'(vx[i][1]));
      chk($sformatf("run%0d.fsm_x", i), 32'(fsm_x), 32'(vx[i][0]));
      chk($sformatf("run%0d.unlocked", i), 32'(unlocked), 1);
    end
    ovr_en = 1'b1; ovr_val = 4'b1111;
    @(posedge clk); #1;
    ovr_en = 1'b0;
    chk("run_bh.fail_code", 32'(fail_code), 3);
    chk("run_bh.fail", 32'(fail), 1);
    chk("run_bh.unlocked", 32'(unlocked), 0);
    chk("run_bh.fsm_en", 32'(fsm_en), 0);

    run_and_check("wrong", 4'b1000, 5'b11100, 1'b0);
    run_and_check("notinit", 4'b0011, CORRECT, 1'b0);
    run_and_check("keychg", 4'b1000, CORRECT, 1'b1);
    run_and_check("lastbit", 4'b1000, 5'b11111, 1'b0);

    // Asynchronous reset in the middle of LOAD
    prep(4'b1000);
    key_in = CORRECT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.fsm_en", 32'(fsm_en), 0);
    chk("midrst.fsm_x", 32'(fsm_x), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.unlocked", 32'(unlocked), 0);
    chk("midrst.fail", 32'(fail), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart.fail", 32'(fail), 1);
    chk("restart.fail_code", 32'(fail_code), 1);
    chk("restart.fsm_en", 32'(fsm_en), 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("restart2.fail_code", 32'(fail_code), 1);
    chk("restart2.busy", 32'(busy), 0);
    chk("restart2.fsm_en", 32'(fsm_en), 0);

    // Randomized attempts
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0: rk = CORRECT;
        1: rk = CORRECT ^ (5'b00001 << $urandom_range(0, 4));
        default: rk = 5'($urandom);
      endcase
      rs = 4'b1000;
      if ($urandom_range(0, 3) == 0) begin
        rs = 4'($urandom);
        if (rs == 4'b1000) rs = 4'b0101;
      end
      run_and_check($sformatf("rnd%0d", n), rs, rk, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
